// File: rtl/selftest_monitor.sv
// Self-check harness beside the processor: sequences its reset, snoops regfile writebacks and
// compares them in order against a loadable table of expected writes.
module selftest_monitor #(
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned ERR_W      = 8,
    localparam int unsigned IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int unsigned CHK_W     = $clog2(NUM_CHECKS + 1),
    localparam int unsigned CYC_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  exp_we,
    input  logic [IDX_W-1:0]      exp_idx,
    input  logic [REG_ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0]     exp_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  cpu_reset,
    output logic [CHK_W-1:0]      check_idx,
    output logic [ERR_W-1:0]      errors,
    output logic [CYC_W-1:0]      cycle_count,
    output logic                  timeout,
    output logic                  done,
    output logic                  pass
);

    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned ENT_W = REG_ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        RESET_DUT,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [RST_W-1:0] rst_cnt;
    logic [ENT_W-1:0] exp_table [NUM_CHECKS];

    logic             evt_c;
    logic             last_c;
    logic             tmo_c;
    logic [ENT_W-1:0] exp_entry_c;
    logic [ERR_W-1:0] err_next_c;

    // Expected-write table: loaded only while idle, deliberately not reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && exp_we && 32'(exp_idx) < NUM_CHECKS) begin
            exp_table[exp_idx] <= {exp_addr, exp_data};
        end
    end

    // Writeback qualification and compare against the current table entry.
    always_comb begin
        exp_entry_c = exp_table[check_idx[IDX_W-1:0]];
        evt_c       = (state == RUN) && wb_en && (wb_addr != '0);
        last_c      = (check_idx == CHK_W'(NUM_CHECKS - 1));
        tmo_c       = (cycle_count == CYC_W'(TIMEOUT - 1));
        err_next_c  = errors;
        if (evt_c && ({wb_addr, wb_data} != exp_entry_c) && (errors != '1)) begin
            err_next_c = errors + ERR_W'(1);
        end
    end

    // Sequencer with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            cpu_reset   <= 1'b1;
            check_idx   <= '0;
            errors      <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    cpu_reset <= 1'b1;
                    if (start) begin
                        state       <= RESET_DUT;
                        rst_cnt     <= '0;
                        check_idx   <= '0;
                        errors      <= '0;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                    end
                end
                RESET_DUT: begin
                    if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                    end else begin
                        cpu_reset <= 1'b1;
                        rst_cnt   <= rst_cnt + RST_W'(1);
                    end
                end
                RUN: begin
                    cycle_count <= cycle_count + CYC_W'(1);
                    errors      <= err_next_c;
                    if (evt_c) begin
                        check_idx <= check_idx + CHK_W'(1);
                    end
                    // A final compare on the timeout edge wins over the timeout.
                    if (evt_c && last_c) begin
                        state     <= DONE;
                        cpu_reset <= 1'b1;
                        done      <= 1'b1;
                        pass      <= (err_next_c == '0);
                    end else if (tmo_c) begin
                        state     <= DONE;
                        cpu_reset <= 1'b1;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        pass      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule
